// File: rtl/psum_ofifo_if.sv
// Bus between the MAC array bottom row, the psum output FIFO and the SFU/writeback stage.
// master: array + reader side; slave: the FIFO itself.
interface psum_ofifo_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
);
    logic [col-1:0]         wr;
    logic [psum_bw*col-1:0] in;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_rd_ack;
    logic                   o_ovf;
    logic                   o_unf;

    modport master (
        output wr, in, rd,
        input  out, o_valid, o_full, o_ready, o_rd_ack, o_ovf, o_unf
    );

    modport slave (
        input  wr, in, rd,
        output out, o_valid, o_full, o_ready, o_rd_ack, o_ovf, o_unf
    );
endinterface

// File: rtl/psum_ofifo.sv
// Per-column psum FIFOs that absorb the array's column skew and pop one aligned vector per read.
// Status flags come only from registered counts; out is registered with one-cycle read latency.
module psum_ofifo #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16
) (
    input logic         clk,
    input logic         reset,
    psum_ofifo_if.slave bus
);
    localparam int unsigned AW      = $clog2(depth);
    localparam logic [AW:0] CntFull = (AW+1)'(depth);

    logic [psum_bw-1:0]     mem  [col][depth];
    logic [AW-1:0]          wptr [col];
    logic [AW-1:0]          rptr [col];
    logic [AW:0]            cnt  [col];
    logic [col-1:0]         wacc;
    logic [col-1:0]         wdrop;
    logic                   valid_all;
    logic                   full_any;
    logic                   pop;
    logic [psum_bw*col-1:0] out_q;
    logic                   rd_ack_q;
    logic                   ovf_q;
    logic                   unf_q;

    always_comb begin
        valid_all = 1'b1;
        full_any  = 1'b0;
        wacc      = '0;
        wdrop     = '0;
        for (int c = 0; c < col; c++) begin
            if (cnt[c] == '0) valid_all = 1'b0;
            if (cnt[c] == CntFull) full_any = 1'b1;
            // Full-ness uses the pre-edge count, so a same-edge pop cannot rescue a write.
            wacc[c]  = bus.wr[c] && (cnt[c] != CntFull);
            wdrop[c] = bus.wr[c] && (cnt[c] == CntFull);
        end
        pop = bus.rd && valid_all;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
            end
            out_q    <= '0;
            rd_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ack_q <= pop;
            if (|wdrop) ovf_q <= 1'b1;
            if (bus.rd && !valid_all) unf_q <= 1'b1;
            for (int c = 0; c < col; c++) begin
                if (wacc[c]) wptr[c] <= wptr[c] + 1'b1;
                if (pop) begin
                    rptr[c] <= rptr[c] + 1'b1;
                    out_q[psum_bw*c +: psum_bw] <= mem[c][rptr[c]];
                end
                if (wacc[c] && !pop) cnt[c] <= cnt[c] + 1'b1;
                else if (!wacc[c] && pop) cnt[c] <= cnt[c] - 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wacc[c] && !reset) mem[c][wptr[c]] <= bus.in[psum_bw*c +: psum_bw];
        end
    end

    assign bus.out      = out_q;
    assign bus.o_valid  = valid_all;
    assign bus.o_full   = full_any;
    assign bus.o_ready  = ~full_any;
    assign bus.o_rd_ack = rd_ack_q;
    assign bus.o_ovf    = ovf_q;
    assign bus.o_unf    = unf_q;
endmodule
